ika87ad_mcseq: RTL and testbench

IKA87AD_MCSEQ -- requirements
Module: IKA87AD_mcseq

---
 rtl/ika87ad_mcseq_pkg.sv | 48 ++++
 rtl/ika87ad_mcseq_if.sv | 24 ++
 rtl/ika87ad_tcnt.sv | 34 +++
 rtl/ika87ad_mcseq.sv | 144 ++++++++++++++
 tb/tb_ika87ad_mcseq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ika87ad_mcseq_pkg.sv
// rtl/ika87ad_mcseq_pkg.sv - shared mnemonics for the IKA87AD microcode sequencer
// Contents: MCTYPE codes, bus operation codes, fixed ROM addresses,
//           microcode word field positions, sequencer state enum and helpers.
package ika87ad_mcseq_pkg;

    localparam logic [1:0] MCTYPE0 = 2'd0;
    localparam logic [1:0] MCTYPE1 = 2'd1;
    localparam logic [1:0] MCTYPE2 = 2'd2;
    localparam logic [1:0] MCTYPE3 = 2'd3;

    localparam logic [1:0] RD3  = 2'd0;
    localparam logic [1:0] RD4  = 2'd1;
    localparam logic [1:0] WR3  = 2'd2;
    localparam logic [1:0] IDLE = 2'd3;

    // Fixed microcode addresses: opcode fetch/decode, interrupt entry,
    // and the suspend range (upper nibble of the address).
    localparam logic [7:0] IRD       = 8'h00;
    localparam logic [7:0] INT_ENTRY = 8'hE0;
    localparam logic [3:0] SUSP      = 4'hF;

    localparam int F_MCTYPE_HI = 17;
    localparam int F_MCTYPE_LO = 16;
    localparam int F_FLAG      = 15;
    localparam int F_END       = 14;
    localparam int F_NOP       = 13;
    localparam int F_NOP2      = 9;
    localparam int F_BUSOP_HI  = 1;
    localparam int F_BUSOP_LO  = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        NOPX,
        HALT
    } mc_state_e;

    function automatic logic is_susp(input logic [7:0] addr);
        return addr[7:4] == SUSP;
    endfunction

    // Index of the final T-state of a step for the given bus operation.
    function automatic logic [1:0] step_last(input logic [1:0] op);
        return (op == RD4) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/ika87ad_mcseq_if.sv
// rtl/ika87ad_mcseq_if.sv - decoder, microcode ROM and bus signals of the sequencer
// Signals: i_DEC_VALID/i_DEC_ADDR (decoder handshake), i_MCROM_DATA,
//          o_MCROM_READ_TICK/o_MCROM_ADDR (ROM), i_WAIT, o_BUS_OP, o_BUS_T.
// Modports: master = sequencer side, slave = decoder/ROM/bus side.
interface ika87ad_mcseq_if;
    logic        i_DEC_VALID;
    logic [7:0]  i_DEC_ADDR;
    logic [17:0] i_MCROM_DATA;
    logic        o_MCROM_READ_TICK;
    logic [7:0]  o_MCROM_ADDR;
    logic        i_WAIT;
    logic [1:0]  o_BUS_OP;
    logic [1:0]  o_BUS_T;

    modport master (
        input  i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA, i_WAIT,
        output o_MCROM_READ_TICK, o_MCROM_ADDR, o_BUS_OP, o_BUS_T
    );

    modport slave (
        output i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA, i_WAIT,
        input  o_MCROM_READ_TICK, o_MCROM_ADDR, o_BUS_OP, o_BUS_T
    );
endinterface

// File: rtl/ika87ad_tcnt.sv
// rtl/ika87ad_tcnt.sv - T-state counter with bus wait handling
// Ports: i_CLK, i_RST_n (async, active low), i_CEN (T-state enable),
//        i_CLR (hold count at 0), i_WAIT, i_OP (current bus op),
//        o_T (T index), o_STEP_END (last T-state of the step on this tick).
module ika87ad_tcnt
    import ika87ad_mcseq_pkg::*;
(
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic       i_CEN,
    input  logic       i_CLR,
    input  logic       i_WAIT,
    input  logic [1:0] i_OP,
    output logic [1:0] o_T,
    output logic       o_STEP_END
);
    logic hold;

    // Wait stretches T=1 of real bus cycles only; IDLE steps never stall.
    assign hold       = i_WAIT && (i_OP != IDLE) && (o_T == 2'd1);
    assign o_STEP_END = i_CEN && !i_CLR && !hold && (o_T == step_last(i_OP));

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_T <= 2'd0;
        end else if (i_CEN) begin
            if (i_CLR || o_STEP_END) begin
                o_T <= 2'd0;
            end else if (!hold) begin
                o_T <= o_T + 2'd1;
            end
        end
    end
endmodule

// File: rtl/ika87ad_mcseq.sv
// rtl/ika87ad_mcseq.sv - microcode sequencer: fetch, decode, microcode execution, halt
// Ports: i_CLK, i_RST_n (async, active low), i_CEN (T-state enable),
//        i_STEP (only when IKA87AD_MCSEQ_SINGLESTEP_EN is defined),
//        i_INT_PEND, bus (ika87ad_mcseq_if.master: decoder, ROM, bus op/T),
//        o_MC_VALID, o_IRD, o_HALTED, o_FLAG_UPD.
// Macro IKA87AD_MCSEQ_SINGLESTEP_EN: FETCH waits at T0 for a rising i_STEP.
module ika87ad_mcseq
    import ika87ad_mcseq_pkg::*;
(
    input  logic i_CLK,
    input  logic i_RST_n,
    input  logic i_CEN,
`ifdef IKA87AD_MCSEQ_SINGLESTEP_EN
    input  logic i_STEP,
`endif
    input  logic i_INT_PEND,
    ika87ad_mcseq_if.master bus,
    output logic o_MC_VALID,
    output logic o_IRD,
    output logic o_HALTED,
    output logic o_FLAG_UPD
);
    mc_state_e   state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        rom_tick, cnt_clr, step_end, fetch_stall;
    logic [1:0]  op, t;
    logic [17:0] word;
    logic [1:0]  w_busop;
    logic        w_end, w_flag, w_nop, w_nop2, w_type3;

    assign word    = bus.i_MCROM_DATA;
    assign w_busop = word[F_BUSOP_HI:F_BUSOP_LO];
    assign w_end   = word[F_END];
    assign w_flag  = word[F_FLAG];
    assign w_type3 = word[F_MCTYPE_HI:F_MCTYPE_LO] == MCTYPE3;
    assign w_nop   = w_type3 && word[F_NOP];
    assign w_nop2  = w_type3 && word[F_NOP2];

    wire unused_word = ^{word[12:10], word[8:2]};

`ifdef IKA87AD_MCSEQ_SINGLESTEP_EN
    logic step_q, step_armed;

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            step_q     <= 1'b0;
            step_armed <= 1'b0;
        end else begin
            step_q <= i_STEP;
            if (i_STEP && !step_q) begin
                step_armed <= 1'b1;
            end else if (i_CEN && state_q == FETCH && t == 2'd0) begin
                step_armed <= 1'b0;
            end
        end
    end

    assign fetch_stall = (state_q == FETCH) && (t == 2'd0) && !step_armed;
`else
    assign fetch_stall = 1'b0;
`endif

    // Bus op and counter clear depend only on registered state and the ROM
    // word, keeping them outside the step_end feedback path.
    assign op = (state_q == FETCH) ? RD4 :
                (state_q == EXEC)  ? w_busop : IDLE;
    assign cnt_clr = (state_q == DECODE) || (state_q == HALT) || fetch_stall;

    ika87ad_tcnt u_tcnt (
        .i_CLK      (i_CLK),
        .i_RST_n    (i_RST_n),
        .i_CEN      (i_CEN),
        .i_CLR      (cnt_clr),
        .i_WAIT     (bus.i_WAIT),
        .i_OP       (op),
        .o_T        (t),
        .o_STEP_END (step_end)
    );

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q <= FETCH;
            addr_q  <= IRD;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rom_tick = 1'b0;
        case (state_q)
            FETCH: begin
                if (step_end) state_d = DECODE;
            end
            DECODE: begin
                if (i_CEN && bus.i_DEC_VALID) begin
                    addr_d   = bus.i_DEC_ADDR;
                    rom_tick = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (step_end) begin
                    if (w_end) begin
                        if (is_susp(addr_q)) begin
                            state_d = HALT;
                        end else if (i_INT_PEND) begin
                            addr_d   = INT_ENTRY;
                            rom_tick = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        // Next word is read now; NOPX then idles without touching the ROM.
                        addr_d   = addr_q + 8'd1;
                        rom_tick = 1'b1;
                        if (w_nop2) state_d = NOPX;
                    end
                end
            end
            NOPX: begin
                if (step_end) state_d = EXEC;
            end
            HALT: begin
                if (i_CEN && i_INT_PEND) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // The ROM sees the new address during the tick cycle and registers the word on that edge.
    assign bus.o_MCROM_ADDR      = addr_d;
    assign bus.o_MCROM_READ_TICK = rom_tick;
    assign bus.o_BUS_OP          = op;
    assign bus.o_BUS_T           = t;

    assign o_MC_VALID = i_CEN && (state_q == EXEC) && (t == 2'd2) && !w_nop;
    assign o_FLAG_UPD = o_MC_VALID && w_flag;
    assign o_IRD      = state_q == DECODE;
    assign o_HALTED   = state_q == HALT;
endmodule

// File: tb/tb_ika87ad_mcseq.sv
// tb/tb_ika87ad_mcseq.sv - self-checking bench for ika87ad_mcseq
module tb_ika87ad_mcseq;
    import ika87ad_mcseq_pkg::*;

    localparam logic [7:0] MVI_R_IM  = 8'h10;
    localparam logic [7:0] LXI       = 8'h20;
    localparam logic [7:0] MOV_MEM_R = 8'h30;
    localparam logic [7:0] JMP       = 8'h40;
    localparam logic [7:0] RANDP     = 8'h80;
    localparam logic [7:0] SUSP_E    = 8'hF0;

    typedef struct {
        logic       wt, dv, ip;
        logic [7:0] da;
        logic [1:0] op, t;
        logic       tk;
        logic [7:0] ad;
        logic       mv, fl, ird, hlt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, cen, int_pend;
`ifdef IKA87AD_MCSEQ_SINGLESTEP_EN
    logic step;
`endif
    logic mc_valid, ird, halted, flag_upd;
    logic [17:0] rom [256];
    logic [17:0] rom_q = '0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [7:0] m_addr;
    logic [7:0] prev_ad;
    bit gap_en;

    ika87ad_mcseq_if mif();

    always #5 clk = ~clk;

    always @(posedge clk) if (mif.o_MCROM_READ_TICK) rom_q <= rom[mif.o_MCROM_ADDR];
    assign mif.i_MCROM_DATA = rom_q;

    ika87ad_mcseq dut (
        .i_CLK      (clk),
        .i_RST_n    (rst_n),
        .i_CEN      (cen),
`ifdef IKA87AD_MCSEQ_SINGLESTEP_EN
        .i_STEP     (step),
`endif
        .i_INT_PEND (int_pend),
        .bus        (mif),
        .o_MC_VALID (mc_valid),
        .o_IRD      (ird),
        .o_HALTED   (halted),
        .o_FLAG_UPD (flag_upd)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [17:0] mkw(input logic [1:0] ty, input logic fl, input logic en,
                                        input logic nop, input logic nop2, input logic [1:0] bo);
        logic [17:0] w;
        w = '0;
        w[17:16] = ty; w[15] = fl; w[14] = en; w[13] = nop; w[9] = nop2; w[1:0] = bo;
        return w;
    endfunction

    function automatic exp_t noise();
        exp_t e;
        e.wt = rb(); e.dv = rb(); e.ip = rb(); e.da = 8'($urandom);
        e.op = IDLE; e.t = 2'd0; e.tk = 1'b0; e.ad = m_addr;
        e.mv = 1'b0; e.fl = 1'b0; e.ird = 1'b0; e.hlt = 1'b0;
        return e;
    endfunction

    function automatic int nwsel(input int wfix);
        if (wfix >= 0) return wfix;
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // One bus step: RD4 lasts 4 T-states, others 3; T=1 repeats nw times on real bus ops.
    // kind: 0 fetch, 1 exec (MC_VALID at T index 2), 2 NOPX idle.
    task automatic push_step(input logic [1:0] op, input int nw, input int kind,
                             input logic mvok, input logic fl);
        exp_t e;
        int len, reps;
        len = (op == RD4) ? 4 : 3;
        for (int t = 0; t < len; t++) begin
            reps = (t == 1 && op != IDLE) ? nw + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                e = noise();
                e.op = op; e.t = 2'(t);
                if (t == 1 && op != IDLE) e.wt = (r < nw);
                if (kind == 1 && t == 2) begin e.mv = mvok; e.fl = mvok & fl; end
                q.push_back(e);
            end
        end
    endtask

    task automatic plan_instr(input logic [7:0] entry, input logic int_end, input int wfix);
        exp_t e;
        logic [7:0] a;
        logic [17:0] w;
        logic ie, done;
        ie = int_end;
        push_step(RD4, nwsel(wfix), 0, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) begin
            e = noise(); e.dv = 1'b0; e.ird = 1'b1; q.push_back(e);
        end
        e = noise(); e.dv = 1'b1; e.da = entry; e.ird = 1'b1; e.tk = 1'b1; e.ad = entry;
        q.push_back(e);
        m_addr = entry;
        a = entry;
        done = 1'b0;
        for (int guard = 0; guard < 16 && !done; guard++) begin
            w = rom[a];
            push_step(w[1:0], nwsel(wfix), 1, !(w[17:16] == 2'd3 && w[13]), w[15]);
            e = q.pop_back();
            if (w[14]) begin
                if (a[7:4] == 4'hF) begin
                    q.push_back(e);
                    repeat ($urandom_range(1, 3)) begin
                        e = noise(); e.ip = 1'b0; e.hlt = 1'b1; q.push_back(e);
                    end
                    e = noise(); e.ip = 1'b1; e.hlt = 1'b1; q.push_back(e);
                    done = 1'b1;
                end else if (ie) begin
                    e.ip = 1'b1; e.tk = 1'b1; e.ad = INT_ENTRY; q.push_back(e);
                    m_addr = INT_ENTRY; a = INT_ENTRY; ie = 1'b0;
                end else begin
                    e.ip = 1'b0; q.push_back(e);
                    done = 1'b1;
                end
            end else begin
                a = a + 8'd1;
                e.tk = 1'b1; e.ad = a; q.push_back(e);
                m_addr = a;
                if (w[17:16] == 2'd3 && w[9]) push_step(IDLE, 0, 2, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic run_q();
        exp_t e;
        int g;
        while (q.size() > 0) begin
            e = q.pop_front();
            g = (gap_en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            for (int i = 0; i < g; i++) begin
                cen = 1'b0; mif.i_WAIT = rb(); mif.i_DEC_VALID = rb();
                mif.i_DEC_ADDR = 8'($urandom); int_pend = rb();
                @(negedge clk);
                chk("gap_tick", 8'(mif.o_MCROM_READ_TICK), 8'd0);
                chk("gap_bus_op", 8'(mif.o_BUS_OP), 8'(e.op));
                chk("gap_bus_t", 8'(mif.o_BUS_T), 8'(e.t));
                chk("gap_addr", mif.o_MCROM_ADDR, prev_ad);
                chk("gap_mc_valid", 8'(mc_valid), 8'd0);
                chk("gap_ird", 8'(ird), 8'(e.ird));
                chk("gap_halted", 8'(halted), 8'(e.hlt));
                @(posedge clk); #1;
            end
            cen = 1'b1; mif.i_WAIT = e.wt; mif.i_DEC_VALID = e.dv;
            mif.i_DEC_ADDR = e.da; int_pend = e.ip;
            @(negedge clk);
            chk("rom_tick", 8'(mif.o_MCROM_READ_TICK), 8'(e.tk));
            chk("bus_op", 8'(mif.o_BUS_OP), 8'(e.op));
            chk("bus_t", 8'(mif.o_BUS_T), 8'(e.t));
            chk("rom_addr", mif.o_MCROM_ADDR, e.ad);
            chk("mc_valid", 8'(mc_valid), 8'(e.mv));
            chk("flag_upd", 8'(flag_upd), 8'(e.fl));
            chk("ird", 8'(ird), 8'(e.ird));
            chk("halted", 8'(halted), 8'(e.hlt));
            prev_ad = e.ad;
            @(posedge clk); #1;
        end
    endtask

    initial begin : main
        exp_t e;
        int n;
        logic [7:0] ent;
        for (int i = 0; i < 256; i++) rom[i] = mkw(MCTYPE0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE);
        rom[8'h10] = mkw(MCTYPE0, 1'b0, 1'b0, 1'b0, 1'b0, RD3);
        rom[8'h11] = mkw(MCTYPE1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE);
        rom[8'h20] = mkw(MCTYPE3, 1'b0, 1'b0, 1'b0, 1'b1, RD3);
        rom[8'h21] = mkw(MCTYPE0, 1'b1, 1'b0, 1'b0, 1'b0, RD3);
        rom[8'h22] = mkw(MCTYPE3, 1'b1, 1'b1, 1'b1, 1'b0, IDLE);
        rom[8'h30] = mkw(MCTYPE0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        rom[8'h31] = mkw(MCTYPE2, 1'b1, 1'b1, 1'b0, 1'b0, WR3);
        rom[8'h40] = mkw(MCTYPE0, 1'b0, 1'b0, 1'b0, 1'b0, RD3);
        rom[8'h41] = mkw(MCTYPE0, 1'b0, 1'b1, 1'b0, 1'b0, RD4);
        rom[8'hE0] = mkw(MCTYPE0, 1'b1, 1'b1, 1'b0, 1'b0, WR3);
        rom[8'hF0] = mkw(MCTYPE0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE);
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++)
            rom[128 + i] = mkw(2'($urandom), rb(), 1'(i == n - 1), rb(), rb(), 2'($urandom));

        rst_n = 1'b0; cen = 1'b1; int_pend = 1'b1;
`ifdef IKA87AD_MCSEQ_SINGLESTEP_EN
        step = 1'b0;
`endif
        mif.i_WAIT = 1'b0; mif.i_DEC_VALID = 1'b1; mif.i_DEC_ADDR = 8'h55;
        m_addr = IRD; prev_ad = IRD; gap_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_op", 8'(mif.o_BUS_OP), 8'(RD4));
        chk("rst_bus_t", 8'(mif.o_BUS_T), 8'd0);
        chk("rst_addr", mif.o_MCROM_ADDR, 8'h00);
        chk("rst_tick", 8'(mif.o_MCROM_READ_TICK), 8'd0);
        chk("rst_mc_valid", 8'(mc_valid), 8'd0);
        chk("rst_ird", 8'(ird), 8'd0);
        chk("rst_halted", 8'(halted), 8'd0);
        chk("rst_flag_upd", 8'(flag_upd), 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        plan_instr(MVI_R_IM, 1'b0, 0);  run_q();
        plan_instr(LXI, 1'b0, 0);       run_q();
        plan_instr(MOV_MEM_R, 1'b0, 2); run_q();
        plan_instr(JMP, 1'b1, 0);       run_q();
        plan_instr(SUSP_E, 1'b0, 0);    run_q();

        gap_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 5))
                0: ent = MVI_R_IM;
                1: ent = LXI;
                2: ent = MOV_MEM_R;
                3: ent = JMP;
                4: ent = RANDP;
                default: ent = SUSP_E;
            endcase
            plan_instr(ent, rb(), -1);
            run_q();
        end

        gap_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = noise(); e.op = RD4; e.t = 2'(i); e.wt = 1'b0; q.push_back(e);
        end
        run_q();
        cen = 1'b1; mif.i_WAIT = 1'b0; mif.i_DEC_VALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bus_op", 8'(mif.o_BUS_OP), 8'(RD4));
        chk("midrst_bus_t", 8'(mif.o_BUS_T), 8'd0);
        chk("midrst_tick", 8'(mif.o_MCROM_READ_TICK), 8'd0);
        chk("midrst_addr", mif.o_MCROM_ADDR, 8'h00);
        chk("midrst_ird", 8'(ird), 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_addr = IRD; prev_ad = IRD;
        plan_instr(MVI_R_IM, 1'b0, -1);
        run_q();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
